// File: rtl/adder_sequencer_pkg.sv
// adder_seq_pkg: shared types and constants for the nibble-serial adder.
//   state_t    - sequencer FSM states (IDLE, RUN, DONE)
//   NIBBLE_W   - width of the time-shared adder slice
//   STATE_RST  - value the state register takes on reset
package adder_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam state_t STATE_RST = IDLE;

endpackage

// File: rtl/adder_sequencer_four_bit_adder.sv
// fourBitAdder: bit-level 4-bit ripple-carry adder cell.
//   c0        - carry in
//   a0..a3    - operand A bits (a0 = LSB)
//   b0..b3    - operand B bits (b0 = LSB)
//   r0..r3    - sum bits (r0 = LSB)
//   r4        - carry out
module fourBitAdder (
  input  logic c0,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  output logic r0,
  output logic r1,
  output logic r2,
  output logic r3,
  output logic r4
);

  logic c1, c2, c3;

  assign r0 = a0 ^ b0 ^ c0;
  assign c1 = (a0 & b0) | (c0 & (a0 ^ b0));
  assign r1 = a1 ^ b1 ^ c1;
  assign c2 = (a1 & b1) | (c1 & (a1 ^ b1));
  assign r2 = a2 ^ b2 ^ c2;
  assign c3 = (a2 & b2) | (c2 & (a2 ^ b2));
  assign r3 = a3 ^ b3 ^ c3;
  assign r4 = (a3 & b3) | (c3 & (a3 ^ b3));

endmodule

// File: rtl/adder_sequencer.sv
// adder_sequencer: adds two W = 4*NIBBLES bit operands by time-sharing one
// fourBitAdder, one nibble per clock, LSB nibble first, with the carry
// registered between nibbles.
//   clk, rst               - clock, async active-high reset
//   in_valid/in_ready      - request handshake (ready only in IDLE, out of reset)
//   in_a, in_b, in_cin     - operands and carry-in, latched at accept
//   in_sub                 - subtract select (only with ADDSEQ_SUB_EN defined)
//   out_valid/out_ready    - response handshake
//   out_sum, out_cout      - result and carry out of the top nibble
//   busy                   - high while an operation is in RUN or DONE
// Optional feature macro: ADDSEQ_SUB_EN (adds in_sub, computes A - B).
module adder_sequencer
  import adder_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
  input  logic                      in_cin,
`ifdef ADDSEQ_SUB_EN
  input  logic                      in_sub,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
  output logic                      out_cout,
  output logic                      busy
);

  localparam int W    = NIBBLE_W * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);
  localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

  state_t              state;
  logic [IDXW-1:0]     idx;
  logic [W-1:0]        a_q, b_q;
  logic                carry_q;
  logic                ready_q;

  logic [NIBBLE_W-1:0] a_nib, b_nib, sum_nib;
  logic                c_out;

  // ready_q is the registered IDLE flag; masking with rst keeps in_ready low
  // during reset while letting it rise on the first cycle after release.
  assign in_ready = ready_q & ~rst;

  // nibble mux into the shared adder
  assign a_nib = a_q[idx*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_q[idx*NIBBLE_W +: NIBBLE_W];

  fourBitAdder u_add (
    .c0 (carry_q),
    .a0 (a_nib[0]), .a1 (a_nib[1]), .a2 (a_nib[2]), .a3 (a_nib[3]),
    .b0 (b_nib[0]), .b1 (b_nib[1]), .b2 (b_nib[2]), .b3 (b_nib[3]),
    .r0 (sum_nib[0]), .r1 (sum_nib[1]), .r2 (sum_nib[2]), .r3 (sum_nib[3]),
    .r4 (c_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STATE_RST;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      ready_q   <= 1'b1;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && ready_q) begin
            a_q <= in_a;
`ifdef ADDSEQ_SUB_EN
            // A - B = A + ~B + 1; cin is ignored when subtracting
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub ? 1'b1 : in_cin;
`else
            b_q     <= in_b;
            carry_q <= in_cin;
`endif
            idx     <= '0;
            ready_q <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          out_sum[idx*NIBBLE_W +: NIBBLE_W] <= sum_nib;
          carry_q <= c_out;
          if (idx == LAST) begin
            // idx is left at LAST so it never wraps; the next accept clears it
            out_cout  <= c_out;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            ready_q   <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          ready_q   <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
